// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style character LCD sequencer.
// LCD_AUTO_INIT_EN selects whether the power-up wait and init ROM are built in.
package lcd_pkg;

   localparam int CNT_W = 23;

   typedef enum logic [2:0] {
`ifdef LCD_AUTO_INIT_EN
      PWRUP,
`endif
      LOAD,
      SETUP,
      PULSE,
      HOLD,
      WAIT,
      IDLE
   } lcd_state_e;

   localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

`ifdef LCD_AUTO_INIT_EN
   // function set 8-bit/2-line, display on, clear, entry mode increment
   localparam logic [7:0] LCD_INIT_SEQ [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
`endif

   // Clear and both encodings of home need the long execution wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data == LCD_CMD_CLEAR || data == LCD_CMD_HOME || data == 8'h03);
   endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// Write-only HD44780 bus sequencer: valid/ready byte requests in, RS/RW/EN/DATA out.
// Define LCD_AUTO_INIT_EN to run the power-up wait and init ROM after every reset.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int SETUP_CYC      = 4,
   parameter int EN_HIGH_CYC    = 25,
   parameter int HOLD_CYC       = 25,
   parameter int CMD_WAIT_CYC   = 2000,
   parameter int CLR_WAIT_CYC   = 82000,
   parameter int PWRUP_WAIT_CYC = 2000000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       req_valid_i,
   output logic       req_ready_o,
   input  logic       req_rs_i,
   input  logic [7:0] req_data_i,
   output logic       init_done_o,
   output logic       busy_o,
   output logic [7:0] lcd_data_o,
   output logic       lcd_rw_o,
   output logic       lcd_rs_o,
   output logic       lcd_en_o,
   output logic       lcd_on_o
);

   // Handshake: a request transfers on a cycle where req_valid_i && req_ready_o are
   // both high; req_ready_o is high only in IDLE after init, inputs are sampled only then.

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYC - 1);
`ifdef LCD_AUTO_INIT_EN
   localparam logic [CNT_W-1:0] RST_CNT   = CNT_W'(PWRUP_WAIT_CYC - 1);
   localparam lcd_state_e       RST_STATE = PWRUP;
`else
   localparam logic [CNT_W-1:0] RST_CNT   = '0;
   localparam lcd_state_e       RST_STATE = IDLE;
`endif

   lcd_state_e       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             init_done_q, done_nxt;
   logic             accept;
   logic             req_rs_q;
   logic [7:0]       req_data_q;
   logic             lcd_rs_q, lcd_en_q, lcd_on_q;
   logic [7:0]       lcd_data_q;
`ifdef LCD_AUTO_INIT_EN
   logic [1:0]       idx, idx_nxt;
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = (cnt == '0) ? cnt : cnt - 1'b1;
      done_nxt  = init_done_q;
      accept    = 1'b0;
`ifdef LCD_AUTO_INIT_EN
      idx_nxt   = idx;
`else
      done_nxt  = 1'b1;
`endif
      case (state)
`ifdef LCD_AUTO_INIT_EN
         PWRUP: if (cnt == '0) begin
            state_nxt = LOAD;
            idx_nxt   = '0;
         end
`endif
         IDLE: if (req_valid_i && req_ready_o) begin
            state_nxt = LOAD;
            accept    = 1'b1;
         end
         LOAD: begin
            state_nxt = SETUP;
            cnt_nxt   = SETUP_LD;
         end
         SETUP: if (cnt == '0) begin
            state_nxt = PULSE;
            cnt_nxt   = EN_LD;
         end
         PULSE: if (cnt == '0) begin
            state_nxt = HOLD;
            cnt_nxt   = HOLD_LD;
         end
         // The bus registers still hold the byte just written, so they pick the wait.
         HOLD: if (cnt == '0) begin
            state_nxt = WAIT;
            cnt_nxt   = is_long_cmd(lcd_rs_q, lcd_data_q) ? CLR_LD : CMD_LD;
         end
         WAIT: if (cnt == '0) begin
`ifdef LCD_AUTO_INIT_EN
            if (!init_done_q && idx != 2'd3) begin
               idx_nxt   = idx + 1'b1;
               state_nxt = LOAD;
            end else begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
`else
            state_nxt = IDLE;
`endif
         end
         default: state_nxt = RST_STATE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= RST_STATE;
         cnt         <= RST_CNT;
         init_done_q <= 1'b0;
         req_rs_q    <= 1'b0;
         req_data_q  <= 8'h00;
         lcd_rs_q    <= 1'b0;
         lcd_data_q  <= 8'h00;
         lcd_en_q    <= 1'b0;
         lcd_on_q    <= 1'b0;
`ifdef LCD_AUTO_INIT_EN
         idx         <= '0;
`endif
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         init_done_q <= done_nxt;
         lcd_en_q    <= (state_nxt == PULSE);
         lcd_on_q    <= 1'b1;
`ifdef LCD_AUTO_INIT_EN
         idx         <= idx_nxt;
`endif
         if (accept) begin
            req_rs_q   <= req_rs_i;
            req_data_q <= req_data_i;
         end
         if (state == LOAD) begin
`ifdef LCD_AUTO_INIT_EN
            if (!init_done_q) begin
               lcd_rs_q   <= 1'b0;
               lcd_data_q <= LCD_INIT_SEQ[idx];
            end else begin
               lcd_rs_q   <= req_rs_q;
               lcd_data_q <= req_data_q;
            end
`else
            lcd_rs_q   <= req_rs_q;
            lcd_data_q <= req_data_q;
`endif
         end
      end
   end

   assign req_ready_o = (state == IDLE) && init_done_q;
   assign busy_o      = ~req_ready_o;
   assign init_done_o = init_done_q;
   assign lcd_data_o  = lcd_data_q;
   assign lcd_rs_o    = lcd_rs_q;
   assign lcd_en_o    = lcd_en_q;
   assign lcd_on_o    = lcd_on_q;
   assign lcd_rw_o    = 1'b0;

   // A zero-length phase would underflow the shared counter.
   param_min_a: assert property (@(posedge clk_i)
      (SETUP_CYC >= 1) && (EN_HIGH_CYC >= 1) && (HOLD_CYC >= 1) &&
      (CMD_WAIT_CYC >= 1) && (CLR_WAIT_CYC >= 1) && (PWRUP_WAIT_CYC >= 1))
      else $error("lcd_ctrl: all cycle parameters must be >= 1");

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl using a small-parameter build; the strobe
// monitor pops expected {rs,data} bytes queued by the request tasks.
module tb_lcd_ctrl;

  localparam int SETUP    = 2;
  localparam int EN_HIGH  = 3;
  localparam int HOLD     = 3;
  localparam int CMD_WAIT = 10;
  localparam int CLR_WAIT = 40;
  localparam int PWRUP    = 50;

  logic       clk;
  logic       rst_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       req_rs_i;
  logic [7:0] req_data_i;
  logic       init_done_o;
  logic       busy_o;
  logic [7:0] lcd_data_o;
  logic       lcd_rw_o;
  logic       lcd_rs_o;
  logic       lcd_en_o;
  logic       lcd_on_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int en_width = 0;
  logic en_prev = 1'b0;
  logic [8:0] mon_exp;
  logic [8:0] exp_q[$];
  int rise_q[$];

  lcd_ctrl #(
    .SETUP_CYC(SETUP), .EN_HIGH_CYC(EN_HIGH), .HOLD_CYC(HOLD),
    .CMD_WAIT_CYC(CMD_WAIT), .CLR_WAIT_CYC(CLR_WAIT), .PWRUP_WAIT_CYC(PWRUP)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rs_i(req_rs_i), .req_data_i(req_data_i),
    .init_done_o(init_done_o), .busy_o(busy_o),
    .lcd_data_o(lcd_data_o), .lcd_rw_o(lcd_rw_o), .lcd_rs_o(lcd_rs_o),
    .lcd_en_o(lcd_en_o), .lcd_on_o(lcd_on_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // strobe monitor / scoreboard
  always @(negedge clk) begin
    if (lcd_en_o === 1'b1 && !en_prev) begin
      rise_q.push_back(cyc);
      en_width = 1;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL en_strobe: unexpected strobe rs=%b data=%h, none queued", lcd_rs_o, lcd_data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({lcd_rw_o, lcd_rs_o, lcd_data_o} !== {1'b0, mon_exp}) begin
          fails++;
          $display("FAIL en_strobe: got rw=%b rs=%b data=%h, need rw=0 rs=%b data=%h",
                   lcd_rw_o, lcd_rs_o, lcd_data_o, mon_exp[8], mon_exp[7:0]);
        end
      end
    end else if (lcd_en_o === 1'b1) begin
      en_width++;
    end else if (en_prev && rst_i === 1'b0) begin
      tests++;
      if (en_width !== EN_HIGH) begin
        fails++;
        $display("FAIL en_width: got %0d cycles, need %0d", en_width, EN_HIGH);
      end
    end
    en_prev = (lcd_en_o === 1'b1);
  end

  // driver tasks
  task automatic wait_ready(input int budget, output bit ok);
    int n = 0;
    while (req_ready_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (req_ready_o === 1'b1);
  endtask

  task automatic wait_init(input int budget, output bit ok);
    int n = 0;
    while (init_done_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (init_done_o === 1'b1);
  endtask

  // Called at a negedge with req_ready_o high; returns at the negedge after accept.
  task automatic send(input logic rs, input logic [7:0] d);
    req_valid_i = 1'b1;
    req_rs_i    = rs;
    req_data_i  = d;
    exp_q.push_back({rs, d});
    @(posedge clk);
    @(negedge clk);
    acc_cyc     = cyc;
    req_valid_i = 1'b0;
    req_rs_i    = ~rs;
    req_data_i  = 8'($urandom_range(0, 255));
  endtask

  task automatic push_init_seq();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  // tests
  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    tests += 8;
    if (req_ready_o !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b need 0", req_ready_o); end
    if (init_done_o !== 1'b0) begin fails++; $display("FAIL rst_init_done: got %b need 0", init_done_o); end
    if (busy_o !== 1'b1) begin fails++; $display("FAIL rst_busy: got %b need 1", busy_o); end
    if (lcd_data_o !== 8'h00) begin fails++; $display("FAIL rst_data: got %h need 00", lcd_data_o); end
    if (lcd_rs_o !== 1'b0) begin fails++; $display("FAIL rst_rs: got %b need 0", lcd_rs_o); end
    if (lcd_en_o !== 1'b0) begin fails++; $display("FAIL rst_en: got %b need 0", lcd_en_o); end
    if (lcd_rw_o !== 1'b0) begin fails++; $display("FAIL rst_rw: got %b need 0", lcd_rw_o); end
    if (lcd_on_o !== 1'b0) begin fails++; $display("FAIL rst_on: got %b need 0", lcd_on_o); end
  endtask

`ifdef LCD_AUTO_INIT_EN
  task automatic test_init();
    bit ok;
    int rel, done_cyc;
    push_init_seq();
    rise_q.delete();
    rel = cyc;
    rst_i = 1'b0;
    wait_init(800, ok);
    done_cyc = cyc;
    tests++;
    if (!ok) begin fails++; $display("FAIL init_timeout: init_done=%b need 1", init_done_o); end
    tests++;
    if (rise_q.size() !== 4) begin fails++; $display("FAIL init_pulses: got %0d need 4", rise_q.size()); end
    if (rise_q.size() == 4) begin
      tests += 5;
      if (rise_q[0] - rel !== PWRUP + 1 + SETUP) begin
        fails++; $display("FAIL init_first_en: got %0d need %0d", rise_q[0] - rel, PWRUP + 1 + SETUP);
      end
      if (rise_q[1] - rise_q[0] !== EN_HIGH + HOLD + CMD_WAIT + 1 + SETUP) begin
        fails++; $display("FAIL init_gap0: got %0d need %0d", rise_q[1] - rise_q[0], EN_HIGH + HOLD + CMD_WAIT + 1 + SETUP);
      end
      if (rise_q[2] - rise_q[1] !== EN_HIGH + HOLD + CMD_WAIT + 1 + SETUP) begin
        fails++; $display("FAIL init_gap1: got %0d need %0d", rise_q[2] - rise_q[1], EN_HIGH + HOLD + CMD_WAIT + 1 + SETUP);
      end
      if (rise_q[3] - rise_q[2] !== EN_HIGH + HOLD + CLR_WAIT + 1 + SETUP) begin
        fails++; $display("FAIL init_gap_clear: got %0d need %0d", rise_q[3] - rise_q[2], EN_HIGH + HOLD + CLR_WAIT + 1 + SETUP);
      end
      if (done_cyc - rise_q[3] !== EN_HIGH + HOLD + CMD_WAIT) begin
        fails++; $display("FAIL init_done_time: got %0d need %0d", done_cyc - rise_q[3], EN_HIGH + HOLD + CMD_WAIT);
      end
    end
    tests++;
    if (req_ready_o !== 1'b1) begin fails++; $display("FAIL init_ready: got %b need 1", req_ready_o); end
  endtask
`else
  task automatic test_init();
    int n0;
    rst_i = 1'b0;
    @(negedge clk);
    tests += 3;
    if (req_ready_o !== 1'b1) begin fails++; $display("FAIL noinit_ready: got %b need 1", req_ready_o); end
    if (init_done_o !== 1'b1) begin fails++; $display("FAIL noinit_done: got %b need 1", init_done_o); end
    if (busy_o !== 1'b0) begin fails++; $display("FAIL noinit_busy: got %b need 0", busy_o); end
    n0 = rise_q.size();
    repeat (PWRUP + 10) @(negedge clk);
    tests++;
    if (rise_q.size() !== n0) begin fails++; $display("FAIL noinit_pulses: got %0d need 0", rise_q.size() - n0); end
  endtask
`endif

  task automatic test_single_write();
    bit ok;
    wait_ready(800, ok);
    send(1'b1, 8'h41);
    tests += 2;
    if (req_ready_o !== 1'b0) begin fails++; $display("FAIL wr_ready_drop: got %b need 0", req_ready_o); end
    if (busy_o !== 1'b1) begin fails++; $display("FAIL wr_busy: got %b need 1", busy_o); end
    @(negedge clk);
    tests++;
    if ({lcd_rs_o, lcd_data_o} !== {1'b1, 8'h41}) begin
      fails++; $display("FAIL wr_bus: got rs=%b data=%h need rs=1 data=41", lcd_rs_o, lcd_data_o);
    end
    wait_ready(200, ok);
    tests += 3;
    if (!ok) begin fails++; $display("FAIL wr_timeout: ready=%b need 1", req_ready_o); end
    if (cyc - acc_cyc !== 1 + SETUP + EN_HIGH + HOLD + CMD_WAIT) begin
      fails++; $display("FAIL wr_occupancy: got %0d need %0d", cyc - acc_cyc, 1 + SETUP + EN_HIGH + HOLD + CMD_WAIT);
    end
    if (rise_q.size() == 0 || rise_q[$] - acc_cyc !== 1 + SETUP) begin
      fails++; $display("FAIL wr_en_latency: got %0d need %0d", (rise_q.size() == 0) ? -1 : rise_q[$] - acc_cyc, 1 + SETUP);
    end
  endtask

  task automatic test_long_cmd();
    bit ok;
    int a1;
    wait_ready(200, ok);
    send(1'b0, 8'h02);
    a1 = acc_cyc;
    wait_ready(200, ok);
    tests++;
    if (cyc - a1 !== 1 + SETUP + EN_HIGH + HOLD + CLR_WAIT) begin
      fails++; $display("FAIL home_wait: got %0d need %0d", cyc - a1, 1 + SETUP + EN_HIGH + HOLD + CLR_WAIT);
    end
    send(1'b0, 8'h80);
    tests++;
    if (lcd_data_o !== 8'h02) begin fails++; $display("FAIL home_bus_hold: got %h need 02", lcd_data_o); end
    @(negedge clk);
    tests++;
    if ({lcd_rs_o, lcd_data_o} !== {1'b0, 8'h80}) begin
      fails++; $display("FAIL ddram_bus: got rs=%b data=%h need rs=0 data=80", lcd_rs_o, lcd_data_o);
    end
    wait_ready(200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL ddram_timeout: ready=%b need 1", req_ready_o); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int pushed = 0;
    int n = 0;
    int r0;
    wait_ready(200, ok);
    r0 = rise_q.size();
    req_valid_i = 1'b1;
    while (pushed < 3 && n < 600) begin
      req_rs_i   = 1'($urandom_range(0, 1));
      req_data_i = 8'($urandom_range(0, 255));
      if (req_ready_o === 1'b1) begin
        exp_q.push_back({req_rs_i, req_data_i});
        pushed++;
      end
      @(negedge clk);
      n++;
    end
    req_valid_i = 1'b0;
    wait_ready(200, ok);
    tests += 3;
    if (!ok) begin fails++; $display("FAIL b2b_timeout: ready=%b need 1", req_ready_o); end
    if (exp_q.size() !== 0) begin fails++; $display("FAIL b2b_lost: %0d bytes never strobed, need 0", exp_q.size()); end
    if (rise_q.size() - r0 !== 3) begin fails++; $display("FAIL b2b_count: got %0d strobes need 3", rise_q.size() - r0); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    int r0, rel;
    wait_ready(200, ok);
    send(1'b1, 8'h55);
    while (lcd_en_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (lcd_en_o !== 1'b1) begin fails++; $display("FAIL mid_reach_pulse: en=%b need 1", lcd_en_o); end
    rst_i = 1'b1;
    @(negedge clk);
    tests += 5;
    if (lcd_en_o !== 1'b0) begin fails++; $display("FAIL mid_en: got %b need 0", lcd_en_o); end
    if (init_done_o !== 1'b0) begin fails++; $display("FAIL mid_init_done: got %b need 0", init_done_o); end
    if (lcd_on_o !== 1'b0) begin fails++; $display("FAIL mid_on: got %b need 0", lcd_on_o); end
    if (req_ready_o !== 1'b0) begin fails++; $display("FAIL mid_ready: got %b need 0", req_ready_o); end
    if (busy_o !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b need 1", busy_o); end
    repeat (2) @(negedge clk);
    r0 = rise_q.size();
`ifdef LCD_AUTO_INIT_EN
    push_init_seq();
    rel = cyc;
    rst_i = 1'b0;
    wait_init(800, ok);
    tests += 3;
    if (!ok) begin fails++; $display("FAIL mid_reinit_timeout: init_done=%b need 1", init_done_o); end
    if (rise_q.size() - r0 !== 4) begin fails++; $display("FAIL mid_reinit_pulses: got %0d need 4", rise_q.size() - r0); end
    if (rise_q.size() <= r0 || rise_q[r0] - rel !== PWRUP + 1 + SETUP) begin
      fails++; $display("FAIL mid_reinit_first_en: got %0d need %0d", (rise_q.size() <= r0) ? -1 : rise_q[r0] - rel, PWRUP + 1 + SETUP);
    end
`else
    rel = cyc;
    rst_i = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready_o !== 1'b1) begin fails++; $display("FAIL mid_ready_after: got %b need 1 (cyc %0d)", req_ready_o, cyc - rel); end
    repeat (30) @(negedge clk);
    tests++;
    if (rise_q.size() !== r0) begin fails++; $display("FAIL mid_no_pulses: got %0d need 0", rise_q.size() - r0); end
`endif
    tests++;
    if (lcd_on_o !== 1'b1) begin fails++; $display("FAIL mid_on_after: got %b need 1", lcd_on_o); end
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_rs_i    = 1'b0;
    req_data_i  = 8'h00;
    test_reset();
    test_init();
    test_single_write();
    test_long_cmd();
    test_back_to_back();
    test_reset_mid();
    test_single_write();
    repeat (5) @(negedge clk);
    tests++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL final_queue: %0d bytes pending, need 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
